// File: rtl/mod_hk_mem.sv
// ---------------------------------------------------------------------------
// mod_hk_mem -- SHA-256 constant store.
//
// On a copy request the 8 initial hash words (H0..H7) and the 64 round
// constants (K0..K63) are moved from an internal ROM into a RAM built from
// four byte-wide banks. RDY is then asserted. From then on any word can be
// read combinationally through the HK port.
//
// Ports:
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset
//   COPY_ROM     level request to start the ROM-to-RAM copy
//   HK_SELECTOR  0 = read H table, 1 = read K table
//   H_ADDR[2:0]  H word index 0..7
//   K_ADDR[5:0]  K word index 0..63
//   HK[31:0]     selected constant word (combinational)
//   RDY          copy complete; RAM contents valid
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// hk_ram_bank -- one 8-bit x 128 bank.
// Synchronous write, asynchronous read, and no reset on the storage.
//
// Ports:
//   clk, wr_en, wr_addr[6:0], wr_data[7:0]  write port
//   rd_addr[6:0], rd_data[7:0]              combinational read port
// ---------------------------------------------------------------------------
module hk_ram_bank (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] buffer [0:127];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  assign rd_data = buffer[rd_addr];

endmodule

// ---------------------------------------------------------------------------
// hk_ram -- 32-bit x 128 RAM built from four byte banks.
// bank_1 holds bits 31:24 and bank_4 holds bits 7:0.
//
// Ports:
//   clk, wr_en, wr_addr[6:0], wr_data[31:0]  write port (all banks in parallel)
//   rd_addr[6:0], rd_data[31:0]              combinational read port
// ---------------------------------------------------------------------------
module hk_ram (
  input  logic        clk,
  input  logic        wr_en,
  input  logic [6:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [6:0]  rd_addr,
  output logic [31:0] rd_data
);

  hk_ram_bank bank_1 (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr),
                      .wr_data(wr_data[31:24]), .rd_addr(rd_addr),
                      .rd_data(rd_data[31:24]));
  hk_ram_bank bank_2 (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr),
                      .wr_data(wr_data[23:16]), .rd_addr(rd_addr),
                      .rd_data(rd_data[23:16]));
  hk_ram_bank bank_3 (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr),
                      .wr_data(wr_data[15:8]), .rd_addr(rd_addr),
                      .rd_data(rd_data[15:8]));
  hk_ram_bank bank_4 (.clk(clk), .wr_en(wr_en), .wr_addr(wr_addr),
                      .wr_data(wr_data[7:0]), .rd_addr(rd_addr),
                      .rd_data(rd_data[7:0]));

endmodule

module mod_hk_mem (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        COPY_ROM,
  input  logic        HK_SELECTOR,
  input  logic [2:0]  H_ADDR,
  input  logic [5:0]  K_ADDR,
  output logic [31:0] HK,
  output logic        RDY
);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  // ROM layout: entries 0..7 are H0..H7, entries 8..71 are K0..K63.
  localparam logic [31:0] ROM_DATA [0:71] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state;
  state_t      state_next;
  logic [6:0]  index;
  logic [6:0]  index_next;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  rd_addr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Once DONE is reached, only reset leaves it; COPY_ROM is ignored there.
  always_comb begin
    state_next = state;
    index_next = index;
    case (state)
      IDLE: begin
        if (COPY_ROM) begin
          state_next = COPY;
          index_next = '0;
        end
      end
      COPY: begin
        index_next = index + 7'd1;
        if (index == 7'd71) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // H words sit at 0..7 and K words at 64..127, so K indices 8..71 are
  // shifted up by 56. This leaves addresses 8..63 unused.
  assign wr_en   = (state == COPY);
  assign wr_addr = (index < 7'd8) ? index : index + 7'd56;
  assign wr_data = (index <= 7'd71) ? ROM_DATA[index] : 32'h0;

  assign rd_addr = HK_SELECTOR ? {1'b1, K_ADDR} : {4'b0000, H_ADDR};
  assign RDY     = (state == DONE);

  hk_ram RAM (
    .clk    (CLK),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(HK)
  );

endmodule

// File: tb/tb_mod_hk_mem.sv
// ---------------------------------------------------------------------------
// tb_mod_hk_mem -- self-checking bench for mod_hk_mem.
// Expected words come from the bench's own SHA-256 constant tables. They are
// pushed to a scoreboard queue when stimulus is driven, then popped and
// compared when the DUT output or RAM contents are sampled.
// ---------------------------------------------------------------------------
module tb_mod_hk_mem;

  logic        CLK;
  logic        RST_N;
  logic        COPY_ROM;
  logic        HK_SELECTOR;
  logic [2:0]  H_ADDR;
  logic [5:0]  K_ADDR;
  logic [31:0] HK;
  logic        RDY;

  int checks = 0;
  int passed = 0;

  logic [31:0] exp_q [$];

  logic [31:0] h_tab [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] k_tab [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  mod_hk_mem dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .COPY_ROM   (COPY_ROM),
    .HK_SELECTOR(HK_SELECTOR),
    .H_ADDR     (H_ADDR),
    .K_ADDR     (K_ADDR),
    .HK         (HK),
    .RDY        (RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hold reset with COPY_ROM low for 255 cycles, then idle after release.
  task automatic test_reset();
    RST_N = 1'b0;
    COPY_ROM = 1'b0;
    HK_SELECTOR = 1'b0;
    H_ADDR = '0;
    K_ADDR = '0;
    for (int c = 0; c < 255; c++) begin
      @(negedge CLK);
      checks++;
      if (RDY !== 1'b0) $display("[TB] FAIL reset_rdy cycle %0d: got %b want 0", c, RDY);
      else passed++;
    end
    RST_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      checks++;
      if (RDY !== 1'b0) $display("[TB] FAIL idle_rdy cycle %0d: got %b want 0", c, RDY);
      else passed++;
    end
  endtask

  // Raise COPY_ROM at a negedge and count posedges until RDY rises.
  // drop_early releases COPY_ROM right after the first sampling edge.
  task automatic test_copy(input string tag, input bit drop_early);
    int rise;
    rise = 0;
    @(negedge CLK);
    COPY_ROM = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge CLK);
      #1;
      if (c == 1 && drop_early) COPY_ROM = 1'b0;
      if (RDY === 1'b1) begin
        rise = c;
        break;
      end
    end
    checks++;
    if (rise !== 73) $display("[TB] FAIL %s_latency: got %0d edges want 73 (0 = timeout)", tag, rise);
    else passed++;

    for (int a = 0; a < 8; a++) exp_q.push_back(h_tab[a]);
    for (int a = 0; a < 64; a++) exp_q.push_back(k_tab[a]);
    for (int i = 0; i < 72; i++) begin
      int a;
      logic [31:0] got;
      logic [31:0] want;
      a = (i < 8) ? i : i + 56;
      got = {dut.RAM.bank_1.buffer[a], dut.RAM.bank_2.buffer[a],
             dut.RAM.bank_3.buffer[a], dut.RAM.bank_4.buffer[a]};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) $display("[TB] FAIL %s_ram addr %0d: got %h want %h", tag, a, got, want);
      else passed++;
    end
  endtask

  // In DONE, COPY_ROM must be ignored whether it is high or low.
  task automatic test_done_hold();
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      COPY_ROM = c[0];
      @(posedge CLK);
      #1;
      checks++;
      if (RDY !== 1'b1) $display("[TB] FAIL done_hold cycle %0d: got %b want 1", c, RDY);
      else passed++;
    end
    COPY_ROM = 1'b0;
  endtask

  // Step H_ADDR 0..7 and then wrap back to 0.
  task automatic test_h_read();
    HK_SELECTOR = 1'b0;
    K_ADDR = 6'd5;
    for (int i = 0; i <= 8; i++) begin
      logic [31:0] want;
      @(negedge CLK);
      H_ADDR = 3'(i);
      exp_q.push_back(h_tab[i % 8]);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (HK !== want) $display("[TB] FAIL h_read addr %0d: got %h want %h", i % 8, HK, want);
      else passed++;
      checks++;
      if (RDY !== 1'b1) $display("[TB] FAIL h_read_rdy addr %0d: got %b want 1", i % 8, RDY);
      else passed++;
    end
  endtask

  // Step K_ADDR 0..63 and then wrap back to 0.
  task automatic test_k_read();
    HK_SELECTOR = 1'b1;
    H_ADDR = 3'd6;
    for (int i = 0; i <= 64; i++) begin
      logic [31:0] want;
      @(negedge CLK);
      K_ADDR = 6'(i);
      exp_q.push_back(k_tab[i % 64]);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (HK !== want) $display("[TB] FAIL k_read addr %0d: got %h want %h", i % 64, HK, want);
      else passed++;
      if (i % 64 == 0) begin
        checks++;
        if (RDY !== 1'b1) $display("[TB] FAIL k_read_rdy addr %0d: got %b want 1", i % 64, RDY);
        else passed++;
      end
    end
  endtask

  // Toggle the selector several times within one clock period.
  task automatic test_selector_switch();
    @(negedge CLK);
    H_ADDR = 3'd3;
    K_ADDR = 6'd3;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want;
      HK_SELECTOR = i[0];
      exp_q.push_back(i[0] ? k_tab[3] : h_tab[3]);
      #1;
      want = exp_q.pop_front();
      checks++;
      if (HK !== want) $display("[TB] FAIL sel_switch step %0d: got %h want %h", i, HK, want);
      else passed++;
    end
  endtask

  // Reset around copy index 30, then run a full copy again.
  task automatic test_reset_mid_copy();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if (RDY !== 1'b0) $display("[TB] FAIL pre_reset_rdy: got %b want 0", RDY);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    COPY_ROM = 1'b1;
    // One edge enters COPY, then 30 edges write indices 0..29.
    repeat (31) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    COPY_ROM = 1'b0;
    #1;
    checks++;
    if (RDY !== 1'b0) $display("[TB] FAIL mid_reset_rdy: got %b want 0", RDY);
    else passed++;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (RDY !== 1'b0) $display("[TB] FAIL held_reset_rdy: got %b want 0", RDY);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    test_copy("recopy", 1'b1);
  endtask

  initial begin
    test_reset();
    test_copy("copy", 1'b0);
    test_done_hold();
    test_h_read();
    test_k_read();
    test_selector_switch();
    test_reset_mid_copy();
    test_h_read();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
